// File: rtl/s1_sequenciador_pontos.sv
// Score sequencer: walks the per-round error memory and deducts a
// fixed penalty per recorded error, saturating the score at zero.
module s1_sequenciador_pontos #(
  parameter int N_RODADAS  = 16,
  parameter int PONTOS_INI = 100,
  parameter int PENALIDADE = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [4:0] num_rodadas,
  input  logic [3:0] mem_erro_dado,
  output logic [3:0] mem_erro_addr,
  output logic       mem_erro_rd,
  output logic [6:0] pontos,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    INICIA  = 3'd1,
    LE      = 3'd2,
    ACUMULA = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [4:0]  LIM_MAX = 5'(N_RODADAS);
  localparam logic [6:0]  PTS_INI = 7'(PONTOS_INI);
  localparam logic [15:0] PEN     = 16'(PENALIDADE);

  estado_t     estado_q;
  logic [6:0]  pontos_q;
  logic [6:0]  pontos_d;
  logic [3:0]  idx_q;
  logic [4:0]  limite_q;
  logic [4:0]  limite_d;
  logic        rd_q;
  logic        ocupado_q;
  logic        pronto_q;
  logic [15:0] desconto;
  logic [15:0] pts_ext;
  logic        ultimo;

  // Wide subtraction so a large penalty can never wrap the score.
  always_comb begin
    pts_ext  = {9'd0, pontos_q};
    desconto = PEN * {12'd0, mem_erro_dado};
    pontos_d = '0;
    if (desconto < pts_ext) begin
      pontos_d = 7'(pts_ext - desconto);
    end
    limite_d = num_rodadas;
    if (num_rodadas > LIM_MAX) begin
      limite_d = LIM_MAX;
    end
    ultimo = ({1'b0, idx_q} == (limite_q - 5'd1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      pontos_q  <= PTS_INI;
      idx_q     <= '0;
      limite_q  <= '0;
      rd_q      <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      rd_q     <= 1'b0;
      pronto_q <= 1'b0;
      unique case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            estado_q  <= INICIA;
            ocupado_q <= 1'b1;
          end
        end
        INICIA: begin
          pontos_q <= PTS_INI;
          idx_q    <= '0;
          limite_q <= limite_d;
          if (limite_d == 5'd0) begin
            estado_q  <= FIM;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
          end else begin
            estado_q <= LE;
            rd_q     <= 1'b1;
          end
        end
        LE: begin
          estado_q <= ACUMULA;
        end
        ACUMULA: begin
          pontos_q <= pontos_d;
          if (ultimo) begin
            estado_q  <= FIM;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
          end else begin
            idx_q    <= idx_q + 4'd1;
            estado_q <= LE;
            rd_q     <= 1'b1;
          end
        end
        FIM: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_erro_addr = idx_q;
  assign mem_erro_rd   = rd_q;
  assign pontos        = pontos_q;
  assign ocupado       = ocupado_q;
  assign pronto        = pronto_q;
  assign db_estado     = estado_q;

endmodule

// File: tb/tb_s1_sequenciador_pontos.sv
// Scoreboard bench: driver queues expected reads and completions,
// monitor checks them as the sequencer presents them.
module tb_s1_sequenciador_pontos;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [4:0] num_rodadas = '0;
  logic [3:0] mem_erro_dado = '0;
  logic [3:0] mem_erro_addr;
  logic       mem_erro_rd;
  logic [6:0] pontos;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  typedef struct {
    bit is_rd;
    int cyc;
    int val;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mem [16];
  int         cyc = 0;
  int         total = 0;
  int         passed = 0;

  s1_sequenciador_pontos dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .num_rodadas   (num_rodadas),
    .mem_erro_dado (mem_erro_dado),
    .mem_erro_addr (mem_erro_addr),
    .mem_erro_rd   (mem_erro_rd),
    .pontos        (pontos),
    .ocupado       (ocupado),
    .pronto        (pronto),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock)
    if (mem_erro_rd) mem_erro_dado <= mem[mem_erro_addr];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
  endtask

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if (reset && (mem_erro_rd || pronto)) begin
      if (sb.size() == 0) begin
        chk(mem_erro_rd ? "unexpected_rd" : "unexpected_pronto", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", int'(mem_erro_rd), int'(e.is_rd));
        chk("event_cycle", cyc, e.cyc);
        if (mem_erro_rd) chk("rd_addr", int'(mem_erro_addr), e.val);
        else chk("pontos_final", int'(pontos), e.val);
      end
    end
  end

  task automatic push_run(input int base, input int nrd, input int L,
                          input int pts, input bit fim);
    for (int i = 0; i < nrd; i++) sb.push_back('{1'b1, base + 2 + 2 * i, i});
    if (fim) sb.push_back('{1'b0, base + 2 + 2 * L, pts});
  endtask

  task automatic idle_chk(input int pts);
    chk("idle_state", int'(db_estado), 0);
    chk("idle_ocupado", int'(ocupado), 0);
    chk("held_pontos", int'(pontos), pts);
  endtask

  task automatic run(input logic [4:0] n, input int L, input int pts,
                     input bit disturb);
    int base;
    @(negedge clock);
    base = cyc;
    push_run(base, L, L, pts, 1'b1);
    num_rodadas = n;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    if (disturb) begin
      @(negedge clock);
      chk("disturb_in_le", int'(db_estado), 2);
      iniciar = 1'b1;
      num_rodadas = 5'd10;
      @(negedge clock);
      iniciar = 1'b0;
      num_rodadas = 5'd1;
    end
    while (cyc < base + 2 * L + 4) @(negedge clock);
    idle_chk(pts);
  endtask

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  initial begin
    int base;
    int base2;
    fill(4'd0);
    #2 reset = 1'b0;
    #1;
    chk("rst_estado", int'(db_estado), 0);
    chk("rst_pontos", int'(pontos), 100);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_rd", int'(mem_erro_rd), 0);
    chk("rst_addr", int'(mem_erro_addr), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_no_start", int'(db_estado), 0);

    mem[0] = 4'd1; mem[1] = 4'd0; mem[2] = 4'd2;
    run(5'd3, 3, 85, 1'b0);
    run(5'd0, 0, 100, 1'b0);
    fill(4'd15);
    run(5'd16, 16, 0, 1'b0);
    fill(4'd1);
    run(5'd20, 16, 20, 1'b0);

    fill(4'd0);
    mem[0] = 4'd1; mem[1] = 4'd0; mem[2] = 4'd2;
    run(5'd3, 3, 85, 1'b1);

    // iniciar held high: back-to-back runs
    mem[0] = 4'd1; mem[1] = 4'd0;
    @(negedge clock);
    base = cyc;
    base2 = base + 7;
    push_run(base, 2, 2, 95, 1'b1);
    push_run(base2, 2, 2, 95, 1'b1);
    num_rodadas = 5'd2;
    iniciar = 1'b1;
    while (cyc < base2 + 1) @(negedge clock);
    iniciar = 1'b0;
    while (cyc < base2 + 8) @(negedge clock);
    idle_chk(95);

    // reset during ACUMULA of round 2
    mem[0] = 4'd1; mem[1] = 4'd0; mem[2] = 4'd2;
    @(negedge clock);
    base = cyc;
    push_run(base, 2, 3, 0, 1'b0);
    num_rodadas = 5'd3;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    while (cyc < base + 5) @(negedge clock);
    chk("pre_rst_estado", int'(db_estado), 3);
    chk("pre_rst_pontos", int'(pontos), 95);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_estado", int'(db_estado), 0);
    chk("mid_rst_pontos", int'(pontos), 100);
    chk("mid_rst_ocupado", int'(ocupado), 0);
    chk("mid_rst_pronto", int'(pronto), 0);
    chk("mid_rst_rd", int'(mem_erro_rd), 0);
    chk("mid_rst_addr", int'(mem_erro_addr), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_rst_idle", int'(db_estado), 0);
    run(5'd3, 3, 85, 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/s1_sequenciador_pontos.md
S1_SEQUENCIADOR_PONTOS -- requirements
Module: s1_sequenciador_pontos

Interface
REQ-001 SHALL have parameter N_RODADAS, default 16, maximum number of rounds held in the error memory.
REQ-002 SHALL have parameter PONTOS_INI, default 100, initial score.
REQ-003 SHALL have parameter PENALIDADE, default 5, points deducted per recorded error.
REQ-004 SHALL have port clock, input, 1, single system clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low (0 = reset).
REQ-006 SHALL have port iniciar, input, 1, request to start a score calculation.
REQ-007 SHALL have port num_rodadas, input, 5, number of rounds to evaluate, sampled at start.
REQ-008 SHALL have port mem_erro_dado, input, 4, error count read from the error memory.
REQ-009 SHALL have port mem_erro_addr, output, 4, error memory read address.
REQ-010 SHALL have port mem_erro_rd, output, 1, error memory read enable.
REQ-011 SHALL have port pontos, output, 7, current or final score.
REQ-012 SHALL have port ocupado, output, 1, calculation in progress.
REQ-013 SHALL have port pronto, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port db_estado, output, 3, current FSM state for debug.

Function
REQ-015 SHALL implement the states OCIOSO=0, INICIA=1, LE=2, ACUMULA=3 and FIM=4, and SHALL drive db_estado with the current state code.
REQ-016 OCIOSO: iniciar=1 SHALL move to INICIA; otherwise the FSM SHALL stay in OCIOSO with pontos held.
REQ-017 INICIA SHALL set pontos=PONTOS_INI, round index idx=0, and latch limite=min(num_rodadas, N_RODADAS).
REQ-018 INICIA SHALL go to FIM if limite==0, else to LE.
REQ-019 LE SHALL assert mem_erro_rd=1 with mem_erro_addr=idx, then go to ACUMULA; memory read latency is one cycle, so data is valid during ACUMULA.
REQ-020 ACUMULA SHALL update pontos to pontos - PENALIDADE*mem_erro_dado, saturating at 0, computed with at least 8-bit intermediate width and with no wrap-around.
REQ-021 In ACUMULA, if idx==limite-1 the FSM SHALL go to FIM; otherwise idx SHALL increment and the FSM SHALL go to LE.
REQ-022 FIM SHALL assert pronto=1 for exactly one cycle, then go to OCIOSO.
REQ-023 Latency: with iniciar sampled at edge 0, pronto SHALL be high in cycle 2+2*limite (cycle 2 when limite=0).
REQ-024 ocupado SHALL be 1 in INICIA, LE and ACUMULA, and 0 in OCIOSO and FIM.
REQ-025 iniciar SHALL be ignored in every state except OCIOSO.
REQ-026 iniciar held high SHALL restart the FSM from OCIOSO immediately after FIM.
REQ-027 mem_erro_rd SHALL be 0 outside LE, and mem_erro_addr SHALL be held at idx in all states.
REQ-028 Changes on num_rodadas after INICIA SHALL have no effect on the calculation in progress.
REQ-029 Once pontos reaches 0 it SHALL stay 0 for the remaining rounds, and iteration SHALL still complete all limite rounds.

Reset
REQ-030 reset=0 SHALL immediately force OCIOSO, pontos=PONTOS_INI, idx=0, limite=0, mem_erro_rd=0, ocupado=0, pronto=0 and db_estado=0.
REQ-031 reset asserted mid-calculation SHALL abort the calculation with no pronto pulse, and the first post-reset iniciar SHALL start a fresh calculation.
REQ-032 Reset deassertion SHALL be synchronous to clock; the FSM SHALL leave OCIOSO only on a sampled iniciar=1.

Verification
REQ-033 Scenario: num_rodadas=3 and memory {1,0,2} -> pontos=85, pronto in cycle 8, reads of addresses 0,1,2 in cycles 2,4,6.
REQ-034 Scenario: num_rodadas=0 -> pronto in cycle 2, pontos=100, mem_erro_rd never asserted.
REQ-035 Scenario: num_rodadas=16 and all entries 15 -> pontos saturates to 0 at round 2 and stays 0, pronto in cycle 34.
REQ-036 Scenario: num_rodadas=20 -> limite clamps to 16, addresses 0..15 are read, and address 16 is never issued.
REQ-037 Scenario: iniciar pulsed again during LE, and num_rodadas changed mid-run -> result and timing are identical to an undisturbed run.
REQ-038 Scenario: reset=0 during ACUMULA of round 2 -> outputs immediately take their reset values with no pronto; a new iniciar gives the correct full result.
